fifo_level: RTL and testbench

Parametrised synchronous FIFO; next generation of the team's basic register-file FIFO. Adds:
- full-width read data
- occupancy count
- programmable almost-full/almost-empty flags
- overflow/underflow pulses
- defined simultaneous read/write behaviour at the full and empty boundaries

Sits between the UART/ALU interface stages as the general buffering element.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ram.sv | 31 +++
 rtl/fifo_level.sv | 127 ++++++++++++
 tb/tb_fifo_level.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the fifo_level buffer and its register file.
`default_nettype none

package fifo_pkg;

    // {wr_acc, rd_acc} operation encodings
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_RDWR = 2'b11;

    function automatic int fifo_depth(input int addr_bits);
        return 2 ** addr_bits;
    endfunction

    function automatic int fifo_count_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// fifo_ram: B x 2**W register file, one synchronous write port, one asynchronous read port.
`default_nettype none

module fifo_ram
    import fifo_pkg::*;
#(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_we,
    input  logic [W-1:0] i_waddr,
    input  logic [B-1:0] i_wdata,
    input  logic [W-1:0] i_raddr,
    output logic [B-1:0] o_rdata
);

    logic [B-1:0] mem_q [fifo_depth(W)];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle overwrite at r_ptr is never observed.
    assign o_rdata = mem_q[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_level.sv
// fifo_level: synchronous FIFO with occupancy count, programmable almost flags and
// overflow/underflow pulses. Define FIFO_FWFT_EN for first-word fall-through read data.
`default_nettype none

module fifo_level
    import fifo_pkg::*;
#(
    parameter int B         = 8,
    parameter int W         = 4,
    parameter int AF_THRESH = 2 ** W - 2,
    parameter int AE_THRESH = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_wr,
    input  logic [B-1:0] i_w_data,
    input  logic         i_rd,
    output logic [B-1:0] o_r_data,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_almost_empty,
    output logic         o_almost_full,
    output logic [W:0]   o_count,
    output logic         o_overflow,
    output logic         o_underflow
);

    localparam logic [W:0] DEPTH_C = (W + 1)'(fifo_depth(W));
    localparam logic [W:0] AF_C    = (W + 1)'(AF_THRESH);
    localparam logic [W:0] AE_C    = (W + 1)'(AE_THRESH);

    logic [W-1:0] wptr_q;
    logic [W-1:0] rptr_q;
    logic [W:0]   count_q;
    logic [W:0]   count_d;
    logic         empty_q;
    logic         full_q;
    logic         almost_empty_q;
    logic         almost_full_q;
    logic         overflow_q;
    logic         underflow_q;
    logic         rd_acc;
    logic         wr_acc;
    logic [1:0]   op;
    logic [B-1:0] ram_rdata;

    // A read frees a slot in the same cycle, so a full FIFO can still accept a write.
    assign rd_acc = i_rd & ~empty_q;
    assign wr_acc = i_wr & (~full_q | rd_acc);
    assign op     = {wr_acc, rd_acc};

    always_comb begin
        count_d = count_q;
        case (op)
            OP_WR:   count_d = count_q + 1'b1;
            OP_RD:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_acc) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q        <= count_d;
            empty_q        <= (count_d == '0);
            full_q         <= (count_d == DEPTH_C);
            almost_empty_q <= (count_d <= AE_C);
            almost_full_q  <= (count_d >= AF_C);
            overflow_q     <= i_wr & ~wr_acc;
            underflow_q    <= i_rd & ~rd_acc;
        end
    end

    fifo_ram #(
        .B (B),
        .W (W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_acc),
        .i_waddr (wptr_q),
        .i_wdata (i_w_data),
        .i_raddr (rptr_q),
        .o_rdata (ram_rdata)
    );

`ifdef FIFO_FWFT_EN
    assign o_r_data = ram_rdata;
`else
    logic [B-1:0] r_data_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data_q <= '0;
        end else if (rd_acc) begin
            r_data_q <= ram_rdata;
        end
    end

    assign o_r_data = r_data_q;
`endif

    assign o_empty        = empty_q;
    assign o_full         = full_q;
    assign o_almost_empty = almost_empty_q;
    assign o_almost_full  = almost_full_q;
    assign o_count        = count_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed and randomized checks of fifo_level against a queue-based model.
`default_nettype none

module tb_fifo_level;

    localparam int B     = 8;
    localparam int W     = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_wr;
    logic [B-1:0] i_w_data;
    logic         i_rd;
    logic [B-1:0] o_r_data;
    logic         o_empty;
    logic         o_full;
    logic         o_almost_empty;
    logic         o_almost_full;
    logic [W:0]   o_count;
    logic         o_overflow;
    logic         o_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [B-1:0] model_q[$];
    logic [B-1:0] exp_rdata;
    bit           exp_ovf;
    bit           exp_unf;

    fifo_level #(
        .B         (B),
        .W         (W),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_wr           (i_wr),
        .i_w_data       (i_w_data),
        .i_rd           (i_rd),
        .o_r_data       (o_r_data),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_almost_empty (o_almost_empty),
        .o_almost_full  (o_almost_full),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n = model_q.size();
        check("count", 32'(o_count), 32'(n));
        check("empty", 32'(o_empty), 32'(n == 0));
        check("full", 32'(o_full), 32'(n == DEPTH));
        check("almost_empty", 32'(o_almost_empty), 32'(n <= AE));
        check("almost_full", 32'(o_almost_full), 32'(n >= AF));
        check("overflow", 32'(o_overflow), 32'(exp_ovf));
        check("underflow", 32'(o_underflow), 32'(exp_unf));
`ifdef FIFO_FWFT_EN
        if (n > 0) check("fwft_data", 32'(o_r_data), 32'(model_q[0]));
`else
        check("r_data", 32'(o_r_data), 32'(exp_rdata));
`endif
    endtask

    task automatic step(input bit wr, input logic [B-1:0] data, input bit rd);
        bit ra;
        bit wa;
        @(negedge i_clk);
        i_wr     = wr;
        i_w_data = data;
        i_rd     = rd;
        @(posedge i_clk);
        ra = rd && (model_q.size() > 0);
        wa = wr && ((model_q.size() < DEPTH) || ra);
        exp_ovf = wr && !wa;
        exp_unf = rd && !ra;
        if (ra) exp_rdata = model_q.pop_front();
        if (wa) model_q.push_back(data);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_wr    = 1'b0;
        i_rd    = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        model_q.delete();
        exp_rdata = '0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        check_all();
        check("reset_r_data", 32'(o_r_data), 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset  = 1'b1;
        i_wr     = 1'b0;
        i_rd     = 1'b0;
        i_w_data = '0;
        exp_rdata = '0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        #1;
        check_all();
        check("reset_r_data", 32'(o_r_data), 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Reset mid-stream, then read pulses underflow
        step(1, 8'hA1, 0);
        step(1, 8'hA2, 0);
        do_reset();
        step(0, 8'h00, 1);

        // Fill, overflow, drain
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        step(1, 8'h44, 0);
        step(1, 8'h55, 0);
        step(0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);

        // Full simultaneous read/write
        for (int i = 0; i < 4; i++) step(1, 8'(8'h11 * (i + 1)), 0);
        step(1, 8'h66, 1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);

        // Empty simultaneous read/write
        step(1, 8'h77, 1);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);

        // Pointer wrap with write/read pairs
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(8'h80 + i), 0);
            step(0, 8'h00, 1);
        end

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
